// File: rtl/set_job_scheduler.sv
// Round-robin front end that shares one SET circle-counting engine among
// NREQ requesters, with a watchdog that aborts jobs the engine never completes.
module set_job_scheduler #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [24*NREQ-1:0] req_central,
    input  logic [12*NREQ-1:0] req_radius,
    input  logic [2*NREQ-1:0]  req_mode,
    output logic               set_en,
    output logic [23:0]        set_central,
    output logic [11:0]        set_radius,
    output logic [1:0]         set_mode,
    input  logic               set_busy,
    input  logic               set_valid,
    input  logic [7:0]         set_candidate,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [7:0]         rsp_candidate,
    output logic               rsp_err,
    output logic               sched_busy
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  w_gnt_idx;
    logic            w_gnt_any;
    logic [IDW:0]    w_sum;
    logic [NREQ-1:0] w_ready;

    logic [WDW-1:0]  r_wd;
    logic [WDW-1:0]  w_wd_inc;
    logic            w_timeout;
    logic            w_accept;
    logic            w_issue;
    logic            w_done;

    logic [23:0]     r_job_central;
    logic [11:0]     r_job_radius;
    logic [1:0]      r_job_mode;
    logic [IDW-1:0]  r_job_id;

    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [7:0]      r_rsp_cand;
    logic            r_rsp_err;

    // First pending requester at or after the pointer, wrapping past NREQ-1.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            if (!w_gnt_any && req_valid[w_sum[IDW-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_sum[IDW-1:0];
            end
        end
    end

    assign w_wd_inc  = r_wd + 1'b1;
    assign w_timeout = (w_wd_inc == WDW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_ready  = '0;
        set_en   = 1'b0;
        w_accept = 1'b0;
        w_issue  = 1'b0;
        w_done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_gnt_any) begin
                    w_ready[w_gnt_idx] = 1'b1;
                    w_accept           = 1'b1;
                    w_next             = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!set_busy) begin
                    set_en  = 1'b1;
                    w_issue = 1'b1;
                    w_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (set_valid || w_timeout) begin
                    w_done = 1'b1;
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Grant pulses are suppressed while reset is held so every output reads 0.
    assign req_ready = w_ready & {NREQ{rst}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr      <= '0;
            r_job_central <= '0;
            r_job_radius  <= '0;
            r_job_mode    <= '0;
            r_job_id      <= '0;
        end else if (w_accept) begin
            r_job_central <= req_central[24*w_gnt_idx +: 24];
            r_job_radius  <= req_radius[12*w_gnt_idx +: 12];
            r_job_mode    <= req_mode[2*w_gnt_idx +: 2];
            r_job_id      <= w_gnt_idx;
            if (w_gnt_idx == IDW'(NREQ-1)) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= w_gnt_idx + 1'b1;
            end
        end
    end

    // Watchdog only runs while the engine owns the job, never while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd <= '0;
        end else if (w_issue) begin
            r_wd <= '0;
        end else if (r_state == S_WAIT) begin
            r_wd <= w_wd_inc;
        end
    end

    // A result arriving on the timeout cycle takes priority over the abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_cand  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_done;
            if (w_done) begin
                r_rsp_id   <= r_job_id;
                r_rsp_cand <= set_valid ? set_candidate : 8'd0;
                r_rsp_err  <= !set_valid;
            end
        end
    end

    assign set_central   = r_job_central;
    assign set_radius    = r_job_radius;
    assign set_mode      = r_job_mode;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_rsp_id;
    assign rsp_candidate = r_rsp_cand;
    assign rsp_err       = r_rsp_err;
    assign sched_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_set_job_scheduler.sv
// Scoreboard bench for set_job_scheduler: requester stimulus pushes expected
// responses, a behavioural SET engine answers, and responses pop the queue.
module tb_set_job_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [95:0] req_central;
    logic [47:0] req_radius;
    logic [7:0]  req_mode;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy;
    logic        set_valid;
    logic [7:0]  set_candidate;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_candidate;
    logic        rsp_err;
    logic        sched_busy;

    logic [23:0] rq_c [4];
    logic [11:0] rq_r [4];
    logic [1:0]  rq_m [4];

    assign req_central = {rq_c[3], rq_c[2], rq_c[1], rq_c[0]};
    assign req_radius  = {rq_r[3], rq_r[2], rq_r[1], rq_r[0]};
    assign req_mode    = {rq_m[3], rq_m[2], rq_m[1], rq_m[0]};

    always #5 clk = ~clk;

    set_job_scheduler #(
        .NREQ    (NREQ),
        .IDW     (IDW),
        .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_central   (req_central),
        .req_radius    (req_radius),
        .req_mode      (req_mode),
        .set_en        (set_en),
        .set_central   (set_central),
        .set_radius    (set_radius),
        .set_mode      (set_mode),
        .set_busy      (set_busy),
        .set_valid     (set_valid),
        .set_candidate (set_candidate),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_candidate (rsp_candidate),
        .rsp_err       (rsp_err),
        .sched_busy    (sched_busy)
    );

    typedef struct {
        int          id;
        logic [23:0] c;
        logic [11:0] r;
        logic [1:0]  m;
        int          cand;
        bit          err;
        int          lat;
        int          en_dly;
        int          rsp_dly;
        bit          en_seen;
    } job_t;

    job_t sb [$];

    int n_chk = 0;
    int n_err = 0;
    int cnum = 0;
    int n_grant = 0;
    int n_rsp = 0;
    int g_cyc = 0;
    int en_cyc = 0;
    int gnt_idx = 0;
    int busy_req = 0;
    int busy_cnt = 0;
    int sm_lat = 3;
    int sm_cnt = 0;
    int sm_res = 0;
    int m_rr = 0;
    int seq_k = 0;
    int last_id = 0;
    int last_cand = 0;
    int rr_seq [5];
    bit gnt_now = 0;
    bit hold = 0;
    bit seq_on = 0;
    bit force_v = 0;
    bit prev_rsp = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Count of 8x8 grid points (1..8) selected by the mode's circle set.
    function automatic int golden(input logic [23:0] c, input logic [11:0] r,
                                  input logic [1:0] m);
        int n;
        int cx [3];
        int cy [3];
        int rr [3];
        bit ins [3];
        bit hit;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            cx[i] = int'(c[23-8*i -: 4]);
            cy[i] = int'(c[19-8*i -: 4]);
            rr[i] = int'(r[11-4*i -: 4]);
        end
        for (int x = 1; x <= 8; x++) begin
            for (int y = 1; y <= 8; y++) begin
                for (int i = 0; i < 3; i++) begin
                    ins[i] = ((x-cx[i])*(x-cx[i]) + (y-cy[i])*(y-cy[i]))
                             <= rr[i]*rr[i];
                end
                case (m)
                    2'b00:   hit = ins[0];
                    2'b01:   hit = ins[0] | ins[1];
                    2'b10:   hit = ins[0] ^ ins[1];
                    default: hit = ins[0] & ins[1] & ins[2];
                endcase
                if (hit) n++;
            end
        end
        return n;
    endfunction

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p+k)%4]) return (p+k)%4;
        end
        return -1;
    endfunction

    task automatic monitor();
        job_t e;
        int   g;
        int   exp_g;
        if (prev_rsp && !rsp_valid) begin
            check("rsp_hold_id", rsp_id, last_id);
            check("rsp_hold_cand", rsp_candidate, last_cand);
        end
        prev_rsp = rsp_valid;
        if (rsp_valid) begin
            last_id   = rsp_id;
            last_cand = rsp_candidate;
            check("rsp_sb", sb.size(), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_rsp++;
                check("rsp_id", rsp_id, e.id);
                check("rsp_cand", rsp_candidate, e.cand);
                check("rsp_err", rsp_err, e.err);
                check("rsp_dly", cnum - en_cyc, e.rsp_dly);
                check("hold_cen", set_central, e.c);
                check("hold_mode", set_mode, e.m);
            end
        end
        if (req_ready != 0) begin
            check("rdy_1hot", $countones(req_ready), 1);
            g = 0;
            for (int k = 0; k < 4; k++) if (req_ready[k]) g = k;
            exp_g = rr_pick(req_valid, m_rr);
            check("grant", g, exp_g);
            if (exp_g >= 0) m_rr = (exp_g + 1) % 4;
            if (seq_on && seq_k < 5) begin
                check("rr_seq", g, rr_seq[seq_k]);
                seq_k++;
            end
            e.id      = g;
            e.c       = rq_c[g];
            e.r       = rq_r[g];
            e.m       = rq_m[g];
            e.lat     = sm_lat;
            e.err     = (sm_lat == 0) || (sm_lat > TMO);
            e.cand    = e.err ? 0 : golden(e.c, e.r, e.m);
            e.en_dly  = 1 + busy_req;
            e.rsp_dly = e.err ? TMO + 1 : sm_lat + 1;
            e.en_seen = 0;
            sb.push_back(e);
            n_grant++;
            gnt_now = 1;
            gnt_idx = g;
            g_cyc   = cnum;
        end
        if (set_en) begin
            check("en_sb", sb.size(), 1);
            if (sb.size() > 0) begin
                check("en_once", sb[0].en_seen, 0);
                check("en_dly", cnum - g_cyc, sb[0].en_dly);
                check("en_cen", set_central, sb[0].c);
                check("en_rad", set_radius, sb[0].r);
                check("en_mode", set_mode, sb[0].m);
                sb[0].en_seen = 1;
                sm_cnt = sb[0].lat;
                sm_res = golden(set_central, set_radius, set_mode);
                en_cyc = cnum;
            end
        end
    endtask

    task automatic drive();
        set_valid     = 1'b0;
        set_candidate = 8'($urandom);
        if (gnt_now) begin
            if (!hold) req_valid[gnt_idx] = 1'b0;
            busy_cnt = busy_req;
        end
        set_busy = (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
        if (sm_cnt > 0) begin
            sm_cnt--;
            if (sm_cnt == 0) begin
                set_valid     = 1'b1;
                set_candidate = 8'(sm_res);
            end
        end
        if (force_v) begin
            set_valid     = 1'b1;
            set_candidate = 8'h5a;
            force_v       = 0;
        end
        gnt_now = 0;
    endtask

    task automatic cyc();
        @(negedge clk);
        cnum++;
        if (rst) monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input int max);
        int k;
        k = 0;
        while (k < max && !(req_valid == 0 && sb.size() == 0 && !sched_busy)) begin
            cyc();
            k++;
        end
        check("drain", sb.size() + $countones(req_valid) + int'(sched_busy), 0);
    endtask

    task automatic check_zero(input string t);
        check({t, "_rdy"}, req_ready, 0);
        check({t, "_en"}, set_en, 0);
        check({t, "_cen"}, set_central, 0);
        check({t, "_rad"}, set_radius, 0);
        check({t, "_mode"}, set_mode, 0);
        check({t, "_rv"}, rsp_valid, 0);
        check({t, "_rid"}, rsp_id, 0);
        check({t, "_rcand"}, rsp_candidate, 0);
        check({t, "_rerr"}, rsp_err, 0);
        check({t, "_busy"}, sched_busy, 0);
    endtask

    initial begin
        int k;
        int tgt;
        int saved;
        rst           = 1'b0;
        req_valid     = 4'b0000;
        set_busy      = 1'b0;
        set_valid     = 1'b0;
        set_candidate = 8'h00;
        for (int i = 0; i < 4; i++) begin
            rq_c[i] = 24'h0;
            rq_r[i] = 12'h0;
            rq_m[i] = 2'b00;
        end
        #1;
        check_zero("rst0");
        repeat (3) cyc();
        check_zero("rst");
        rst = 1'b1;
        repeat (2) cyc();
        check("idle_busy", sched_busy, 0);

        // Round-robin with every requester held high.
        for (int i = 0; i < 4; i++) begin
            rq_c[i] = {4'(2+i), 4'(3+i), 4'd5, 4'(i+1), 4'(7-i), 4'd4};
            rq_r[i] = {4'(2+i%2), 4'd2, 4'd3};
            rq_m[i] = 2'(i);
        end
        rr_seq = '{0, 1, 2, 3, 0};
        seq_k  = 0;
        seq_on = 1;
        hold   = 1;
        sm_lat = 3;
        tgt    = n_grant + 5;
        req_valid = 4'b1111;
        k = 0;
        while (n_grant < tgt && k < 200) begin
            cyc();
            k++;
        end
        req_valid = 4'b0000;
        hold   = 0;
        seq_on = 0;
        check("rr_cnt", n_grant, tgt);
        check("rr_seqn", seq_k, 5);
        drain(100);

        // Single job, engine latency 5.
        rq_c[0] = 24'h440000;
        rq_r[0] = 12'h300;
        rq_m[0] = 2'b00;
        sm_lat  = 5;
        req_valid = 4'b0001;
        drain(60);

        // Engine busy for 10 cycles after accept.
        rq_c[2]  = 24'h335577;
        rq_r[2]  = 12'h234;
        rq_m[2]  = 2'b01;
        busy_req = 10;
        sm_lat   = 2;
        req_valid = 4'b0100;
        drain(60);
        busy_req = 0;

        // Watchdog: never, exactly on the limit, one past the limit.
        rq_c[1] = 24'h226688;
        rq_r[1] = 12'h423;
        rq_m[1] = 2'b10;
        sm_lat  = 0;
        req_valid = 4'b0010;
        drain(60);
        rq_c[3] = 24'h554433;
        rq_r[3] = 12'h333;
        rq_m[3] = 2'b11;
        sm_lat  = TMO;
        req_valid = 4'b1000;
        drain(60);
        sm_lat  = TMO + 1;
        req_valid = 4'b0001;
        drain(60);

        // Mode sweep over identical geometry.
        saved = n_rsp;
        for (int i = 0; i < 4; i++) begin
            rq_c[i] = 24'h335546;
            rq_r[i] = 12'h323;
            rq_m[i] = 2'(i);
        end
        sm_lat = 4;
        req_valid = 4'b1111;
        drain(200);
        check("sweep_n", n_rsp - saved, 4);

        // Reset while the engine owns a job.
        rq_c[2] = 24'h447755;
        rq_r[2] = 12'h332;
        sm_lat  = 0;
        req_valid = 4'b0100;
        repeat (5) cyc();
        check("mid_busy", sched_busy, 1);
        rst = 1'b0;
        req_valid = 4'b1111;
        #1;
        check_zero("mid");
        sb.delete();
        sm_cnt   = 0;
        busy_cnt = 0;
        m_rr     = 0;
        prev_rsp = 0;
        repeat (3) cyc();
        req_valid = 4'b0000;
        rst   = 1'b1;
        saved = n_rsp;
        cyc();
        force_v = 1;
        repeat (6) cyc();
        check("late_rsp", n_rsp, saved);
        check("late_busy", sched_busy, 0);
        rr_seq[0] = 0;
        rr_seq[1] = 3;
        seq_k  = 0;
        seq_on = 1;
        sm_lat = 2;
        req_valid = 4'b1001;
        drain(100);
        seq_on = 0;
        check("post_rst_n", seq_k, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/set_job_scheduler.md
Name: set_job_scheduler

Overview:
- Shares one SET circle-counting engine among NREQ independent requesters.
- Round-robin arbitrates their job requests and latches the winning job (central, radius, mode).
- Drives the SET en/central/radius/mode inputs and waits for SET valid.
- Returns the 8-bit candidate count, tagged with the requester id; a watchdog aborts jobs the engine never completes.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester id width, equal to clog2(NREQ).
- TIMEOUT, 1023, max cycles from en issue to SET valid before abort (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester job pending.
- req_ready  out  NREQ  one-hot, 1-cycle grant/accept pulse.
- req_central  in  24*NREQ  packed {x1,y1,x2,y2,x3,y3} per requester, 4 bits each; requester i occupies slice [24i+23:24i].
- req_radius  in  12*NREQ  packed {r1,r2,r3} per requester; slice [12i+11:12i].
- req_mode  in  2*NREQ  00 A, 01 A|B, 10 A^B diff, 11 A&B&C; slice [2i+1:2i].
- set_en  out  1  job strobe to SET.
- set_central  out  24  latched job central.
- set_radius  out  12  latched job radius.
- set_mode  out  2  latched job mode.
- set_busy  in  1  SET busy.
- set_valid  in  1  SET result valid.
- set_candidate  in  8  SET result.
- rsp_valid  out  1  response pulse.
- rsp_id  out  IDW  requester of response.
- rsp_candidate  out  8  result count, 0 on error.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- sched_busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst=0, async): state IDLE, rr pointer 0, all outputs 0, job registers 0, watchdog 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit at or after rr_ptr, searching upward with wrap to 0.
  - Same cycle: req_ready[g]=1 (combinational from registered state and req_valid).
  - Latch the slices of requester g into job_central, job_radius, job_mode and job_id.
  - Set rr_ptr = (g+1) mod NREQ; go to ISSUE.
  - If no req_valid is set: stay in IDLE, req_ready=0.
- ISSUE:
  - If set_busy=0: set_en=1 for exactly one cycle, watchdog cleared, go to WAIT.
  - If set_busy=1: hold in ISSUE with set_en=0, indefinitely; the watchdog does not run.
- WAIT:
  - Watchdog increments every cycle.
  - If set_valid=1: capture set_candidate, rsp_err=0, go to RESP.
  - Else if watchdog reaches TIMEOUT: candidate=0, rsp_err=1, go to RESP.
  - If set_valid arrives on the same cycle the watchdog reaches TIMEOUT, set_valid wins and rsp_err=0.
- RESP:
  - rsp_valid=1 for one cycle with rsp_id=job_id and the captured rsp_candidate and rsp_err.
  - Go to IDLE.
- Hold rules:
  - set_central, set_radius and set_mode are held stable from ISSUE entry through RESP.
  - In IDLE they keep their last values (no glitch on a mode change).
  - rsp_* outputs are registered and hold their last values when rsp_valid=0; only rsp_valid pulses.
- Latency: accept (IDLE) to set_en is 1 cycle if SET is idle. set_valid to rsp_valid is 1 cycle. The next grant comes in the cycle after RESP.
- Minimum per-job overhead: 3 cycles plus the SET compute time.
- Requesters keep req_valid high until they see req_ready. A requester that drops req_valid before being granted is simply skipped.
- Only one job is in flight at a time. set_valid or set_candidate changes outside WAIT are ignored.
- Fairness: with all NREQ requesters permanently asserted, grants rotate 0,1,...,NREQ-1,0,...
- Reset asserted mid-job: FSM returns to IDLE and set_en goes low immediately; the in-flight job is dropped with no response. A set_valid arriving after reset release is ignored.
- req_* bits for requester indices >= NREQ do not exist. Any slice is taken only for the granted index.

Test Plan:
- Single job: after reset, req_valid=0001, central=0x44_00_00, radius=0x300, mode=00. Required: req_ready=0001 pulse; set_en one cycle later with set_central=0x440000, set_radius=0x300; SET model returns 29 after 5 cycles; rsp_valid with rsp_id=0, rsp_candidate=29, rsp_err=0.
- Round-robin: req_valid=1111 held, SET model latency 3. Grant order 0,1,2,3,0 over 5 jobs; rsp_id sequence matches; no requester is granted twice before all are served.
- Busy stall: set_busy=1 for 10 cycles after accept. set_en stays 0 for all 10 cycles and pulses once in the cycle busy falls; no timeout even with TIMEOUT=4.
- Timeout: TIMEOUT=8, SET model never asserts valid. rsp_valid arrives 9 cycles after set_en with rsp_err=1, rsp_candidate=0; next job is granted normally. Variant where valid arrives on the TIMEOUT cycle: rsp_err=0.
- Reset mid-job: rst=0 while in WAIT. All outputs 0 asynchronously, no rsp_valid; after release, a late set_valid pulse produces no response and the first new grant goes to requester 0.
- Mode sweep: four requesters with modes 00, 01, 10, 11 and identical geometry. Each set_mode matches its requester's mode at set_en; the scoreboard checks each rsp_candidate against the golden candidate result files for that mode.
